// File: rtl/ec_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ec_ctrl_pkg
// Shared definitions for the erasure-coding engine job controller.
//   - ec_ctrl_st_e : controller state encoding (also exported for debug)
//   - EC_CNT_W / EC_BM_ROWS / EC_PIPE_LAT : default sizing shared with the
//     engine, bitmatrix memory and buffers
//   - wrap_inc     : increment that wraps to zero after a given last value
// ----------------------------------------------------------------------------
package ec_ctrl_pkg;

    localparam int EC_CNT_W    = 16;
    localparam int EC_BM_ROWS  = 8;
    localparam int EC_PIPE_LAT = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CALC  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } ec_ctrl_st_e;

    // Returns v+1, or 0 when v is already at last.
    function automatic int unsigned wrap_inc(input int unsigned v,
                                             input int unsigned last);
        return (v >= last) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/ec_valid_pipe.sv
// ----------------------------------------------------------------------------
// ec_valid_pipe
// DEPTH-stage 1-bit valid delay line. Tracks which engine pipeline slots hold
// a real result so output-buffer writes line up with engine results.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : synchronous clear of every stage (job abandoned)
//   din       : valid entering the pipeline this cycle
//   dout      : valid leaving the pipeline (registered, DEPTH cycles later)
// ----------------------------------------------------------------------------
module ec_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q <= '0;
        end else if (clr) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/ec_engine_ctrl.sv
// ----------------------------------------------------------------------------
// ec_engine_ctrl
// Job controller for the erasure-coding engine. Runs one encode job of
// job_beats beats: per beat it pops the input buffer, reads a bitmatrix row
// (wrapping address) and fires the engine, then writes each engine result to
// the output buffer exactly PIPE_LAT cycles later. Supports backpressure,
// exact drain, abort and a one-cycle done pulse.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   start, abort         : job start pulse (IDLE only) / abandon job
//   job_beats            : beats in job, latched in LOAD
//   inbuff_empty         : input buffer has no word
//   outbuff_afull        : output buffer lacks PIPE_LAT+1 free entries
//   eng_rstn             : engine synchronous reset, active-low
//   global_reg_wr_en     : control registers writable (IDLE)
//   cntrl_inbuff_rd_en   : pop one input word
//   cntrl_bm_mem_rd_en   : read bitmatrix row bm_row_addr
//   bm_row_addr          : bitmatrix row for the current beat
//   cntrl_eng_calc_en    : engine consumes one beat
//   cntrl_outbuff_wr_en  : push one engine result
//   busy, done           : not IDLE / job-complete pulse
//   dbg_state            : current controller state
//
// Handshake: every enable is a single-cycle strobe and one beat moves in each
// cycle it is high. inbuff_empty and outbuff_afull are the not-ready inputs;
// a beat is issued only when the input side has a word and the output side
// has room for it plus everything already in flight, so the output write is
// never stalled once a beat has been issued.
// ----------------------------------------------------------------------------
module ec_engine_ctrl
    import ec_ctrl_pkg::*;
#(
    parameter int  CNT_W    = EC_CNT_W,
    parameter int  BM_ROWS  = EC_BM_ROWS,
    parameter int  PIPE_LAT = EC_PIPE_LAT,
    localparam int AW       = (BM_ROWS > 1) ? $clog2(BM_ROWS) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] job_beats,
    input  logic             inbuff_empty,
    input  logic             outbuff_afull,
    output logic             eng_rstn,
    output logic             global_reg_wr_en,
    output logic             cntrl_inbuff_rd_en,
    output logic             cntrl_bm_mem_rd_en,
    output logic [AW-1:0]    bm_row_addr,
    output logic             cntrl_eng_calc_en,
    output logic             cntrl_outbuff_wr_en,
    output logic             busy,
    output logic             done,
    output ec_ctrl_st_e      dbg_state
);

    ec_ctrl_st_e      state_q, state_d;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] issue_cnt_q;
    logic [CNT_W-1:0] wr_cnt_q;
    logic [CNT_W-1:0] issue_cnt_inc;
    logic [CNT_W-1:0] wr_cnt_inc;
    logic             issue;
    logic             last_issue;
    logic             last_wr;
    logic             abort_job;

    assign issue_cnt_inc = issue_cnt_q + CNT_W'(1);
    assign wr_cnt_inc    = wr_cnt_q + CNT_W'(1);

    // abort only matters once a job has been accepted; in IDLE it merely
    // blocks a simultaneous start.
    assign abort_job  = abort && (state_q != IDLE);
    assign issue      = (state_q == CALC) && !inbuff_empty && !outbuff_afull;
    assign last_issue = issue && (issue_cnt_inc == len_q);
    assign last_wr    = cntrl_outbuff_wr_en && (wr_cnt_inc == len_q);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d            = state_q;
        eng_rstn           = 1'b1;
        global_reg_wr_en   = 1'b0;
        busy               = 1'b1;
        done               = 1'b0;
        cntrl_inbuff_rd_en = issue;
        cntrl_bm_mem_rd_en = issue;
        cntrl_eng_calc_en  = issue;

        case (state_q)
            IDLE: begin
                eng_rstn         = 1'b0;
                global_reg_wr_en = 1'b1;
                busy             = 1'b0;
                if (start && !abort) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                eng_rstn = 1'b0;
                state_d  = (job_beats == '0) ? DONE : CALC;
            end
            CALC: begin
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The final write can only land here: it trails the last
                // issue by PIPE_LAT >= 1 cycles.
                if (last_wr) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = !abort;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_job) begin
            state_d = IDLE;
        end
    end

    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Job length, beat counters and bitmatrix row address
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q       <= '0;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            bm_row_addr <= '0;
        end else if (state_q == LOAD) begin
            len_q       <= job_beats;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            bm_row_addr <= '0;
        end else begin
            if (issue) begin
                issue_cnt_q <= issue_cnt_inc;
                bm_row_addr <= AW'(wrap_inc(32'(bm_row_addr), BM_ROWS - 1));
            end
            if (cntrl_outbuff_wr_en) begin
                wr_cnt_q <= wr_cnt_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Engine pipeline tracking: an issued beat becomes an output write
    // exactly PIPE_LAT cycles later unless the job is abandoned.
    // ------------------------------------------------------------------
    ec_valid_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_valid_pipe (
        .clk  (clk),
        .rstn (rstn),
        .clr  (abort_job),
        .din  (issue),
        .dout (cntrl_outbuff_wr_en)
    );

endmodule

// File: doc/ec_engine_ctrl.md
# ec_engine_ctrl

Parametrised job controller for the erasure-coding engine; successor to the fixed three-state engine control FSM. It runs one encode job of a programmable number of beats. Per beat it gates input-buffer reads, bitmatrix-memory reads (with wrapping row address) and engine calculation, and tracks the engine pipeline so output-buffer writes line up exactly with engine results. It sits between the control registers and the input buffer, bitmatrix memory, engine and output buffer, and adds backpressure, an exact drain count, abort and a done pulse.

## Interface
- CNT_W, 16, width of beat counters and job length
- BM_ROWS, 8, bitmatrix rows; address wraps at BM_ROWS-1
- PIPE_LAT, 3, engine latency in cycles from calc_en to result (>=1)
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  job start pulse; sampled only in IDLE
- abort  in  1  abandon current job
- job_beats  in  CNT_W  beats in job; latched in LOAD
- inbuff_empty  in  1  input buffer has no word
- outbuff_afull  in  1  output buffer has fewer than PIPE_LAT+1 free entries
- eng_rstn  out  1  engine sync reset, active-low
- global_reg_wr_en  out  1  control registers writable
- cntrl_inbuff_rd_en  out  1  pop one input word
- cntrl_bm_mem_rd_en  out  1  read bitmatrix row
- bm_row_addr  out  $clog2(BM_ROWS)  bitmatrix row for this beat
- cntrl_eng_calc_en  out  1  engine consumes one beat
- cntrl_outbuff_wr_en  out  1  push one engine result
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at job completion

## Operation
- States: IDLE, LOAD, CALC, DRAIN, DONE.
- IDLE: global_reg_wr_en=1, eng_rstn=0. start -> LOAD.
- LOAD (1 cycle): latch job_beats into len_q. Clear issue_cnt, wr_cnt and bm_row_addr. eng_rstn=0. If job_beats==0 -> DONE, else -> CALC.
- issue = (state==CALC) & ~inbuff_empty & ~outbuff_afull.
- On issue, cntrl_inbuff_rd_en, cntrl_bm_mem_rd_en and cntrl_eng_calc_en are all 1 in the same cycle. issue_cnt increments. bm_row_addr increments and wraps BM_ROWS-1 -> 0.
- CALC -> DRAIN on the cycle issue_cnt reaches len_q (last issue).
- The issue pulse enters a PIPE_LAT-deep valid delay line. Its output is cntrl_outbuff_wr_en, which increments wr_cnt.
- DRAIN: no issues. DRAIN -> DONE when a write occurs with wr_cnt==len_q-1.
- DONE (1 cycle): done=1 -> IDLE.
- abort in LOAD/CALC/DRAIN/DONE -> IDLE next cycle. The delay line is cleared and no further outbuff writes occur. done is not asserted.
- start outside IDLE is ignored. abort and start together in IDLE: abort wins and the state stays IDLE.
- Counters are CNT_W wide and never wrap; len_q caps them.
- outbuff_afull is only gated at issue. In-flight results always write, because the afull threshold reserves PIPE_LAT entries.

## Timing
- Reset values: state IDLE, eng_rstn=0, global_reg_wr_en=1, all enables 0, bm_row_addr=0, busy=0, done=0, counters and delay line 0.
- start at cycle t -> LOAD at t+1 -> CALC at t+2; earliest issue is cycle t+2.
- Issue in cycle n -> cntrl_outbuff_wr_en in cycle n+PIPE_LAT.
- Fully unstalled N-beat job: done at cycle t+2+N+PIPE_LAT, then IDLE.
- Throughput: one beat per cycle when unstalled. A stall cycle emits no read, calc or bitmatrix read.
- Enables are combinational from registered state/counters plus inbuff_empty and outbuff_afull. cntrl_outbuff_wr_en comes from a flop.

## Structure
- Shared package ec_ctrl_pkg:
  - state enum ec_ctrl_st_e {IDLE, LOAD, CALC, DRAIN, DONE}
  - default CNT_W, BM_ROWS and PIPE_LAT constants shared with the engine and buffers
- Sub-module ec_valid_pipe #(DEPTH):
  - 1-bit shift register with synchronous clear (used by abort) and asynchronous reset
  - drives cntrl_outbuff_wr_en

## Test plan
- PIPE_LAT=3, job_beats=5, no stalls, start at cycle 0 -> rd/calc high cycles 2-6; bm_row_addr 0..4; wr_en cycles 5-9; done at cycle 10.
- BM_ROWS=8, job_beats=20 -> bm_row_addr sequence 0..7,0..7,0..3; 20 reads and 20 writes total.
- inbuff_empty high cycles 3-4 and outbuff_afull high cycle 6 -> no issue in those cycles; 5-beat job still writes exactly 5 results, each PIPE_LAT after its issue.
- job_beats=0 -> LOAD -> DONE; done at cycle 2; zero reads or writes.
- abort in CALC after 3 issues -> IDLE next cycle; zero further wr_en; no done; eng_rstn=0; next start runs a clean job.
- start pulsed during CALC, and start+abort in IDLE -> both ignored; len_q unchanged.
